// File: rtl/bus_uart_tx_bridge_pkg.sv
// Shared bus/UART bridge definitions: FSM state encodings, default bit
// period and frame-start marker. The matching rx bridge reuses them.
// Optional macro: BRIDGE_PARITY_EN adds the PARITY state (8E1 framing).
package bus_uart_tx_bridge_pkg;

  localparam int unsigned CLKS_PER_BIT_DEF = 434;
  localparam logic        FRAME_MARK       = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_LOAD   = 4'd1,
    ST_START  = 4'd2,
    ST_DATA   = 4'd3,
`ifdef BRIDGE_PARITY_EN
    ST_STOP   = 4'd4,
    ST_PARITY = 4'd5
`else
    ST_STOP   = 4'd4
`endif
  } state_t;

endpackage

// File: rtl/bus_uart_tx_bridge_fifo.sv
// Synchronous frame FIFO for the tx bridge. A push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module bridge_fifo #(
  parameter int WIDTH = 23,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (cnt != '0);
  assign do_push = push && ((cnt != FULL_CNT) || do_pop);
  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign rdata   = mem[rptr];

  // Storage array: data only, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  // Pointers and occupancy
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/bus_uart_tx_bridge.sv
// Bus write to UART tx bridge: each completed bus write is queued as
// {addr, data} and sent as a 3-byte frame {1,addr[14:8]}, addr[7:0], data.
// Optional macro: BRIDGE_PARITY_EN sends each byte 8E1 instead of 8N1.
module bus_uart_tx_bridge
  import bus_uart_tx_bridge_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDRS_WIDTH  = 15,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          wr_en,
  input  logic [ADDRS_WIDTH-1:0]        wr_addr,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  output logic                          busy,
  output logic                          uart_tx,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [3:0]                    state
);

  localparam int ENT_W   = ADDRS_WIDTH + DATA_WIDTH;
  localparam int FRAME_W = ENT_W + 1;
  localparam int DIV_W   = $clog2(CLKS_PER_BIT + 1);
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLKS_PER_BIT - 1);

  state_t             st_q;
  state_t             st_d;
  logic [DIV_W-1:0]   div_q;
  logic [2:0]         bit_idx;
  logic [1:0]         byte_idx;
  logic [FRAME_W-1:0] frame_sr;
  logic [7:0]         cur_byte;
  logic               bit_end;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENT_W-1:0]   fifo_rdata;

  bridge_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (wr_en),
    .pop   (fifo_pop),
    .wdata ({wr_addr, wr_data}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign busy     = fifo_full;
  assign state    = st_q;
  assign bit_end  = (div_q == '0);
  assign cur_byte = frame_sr[FRAME_W-1 -: 8];

  // State register; reset drops any frame in flight
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) st_q <= ST_IDLE;
    else       st_q <= st_d;
  end

  // Next-state decode and FIFO pop
  always_comb begin
    st_d     = st_q;
    fifo_pop = 1'b0;
    case (st_q)
      ST_IDLE:  if (!fifo_empty) st_d = ST_LOAD;
      ST_LOAD: begin
        fifo_pop = 1'b1;
        st_d     = ST_START;
      end
      ST_START: if (bit_end) st_d = ST_DATA;
`ifdef BRIDGE_PARITY_EN
      ST_DATA:   if (bit_end && bit_idx == 3'd7) st_d = ST_PARITY;
      ST_PARITY: if (bit_end) st_d = ST_STOP;
`else
      ST_DATA:   if (bit_end && bit_idx == 3'd7) st_d = ST_STOP;
`endif
      ST_STOP: begin
        if (bit_end) begin
          if (byte_idx != 2'd2) st_d = ST_START;
          else if (!fifo_empty) st_d = ST_LOAD;
          else                  st_d = ST_IDLE;
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  // Bit divider, bit and byte counters: reloaded at every bit boundary
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_q    <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
    end else begin
      if ((st_d != st_q) || (st_q == ST_DATA && bit_end)) div_q <= DIV_LOAD;
      else if (!bit_end)                                  div_q <= div_q - 1'b1;

      if (st_d == ST_START)                   bit_idx <= '0;
      else if (st_q == ST_DATA && bit_end)    bit_idx <= bit_idx + 1'b1;

      if (st_q == ST_LOAD)                    byte_idx <= '0;
      else if (st_q == ST_STOP && bit_end)    byte_idx <= (byte_idx == 2'd2) ? 2'd0 : byte_idx + 1'b1;
    end
  end

  // Frame shift register: current byte sits in the top 8 bits
  always_ff @(posedge clk) begin
    if (st_q == ST_LOAD)
      frame_sr <= {FRAME_MARK, fifo_rdata};
    else if (st_q == ST_STOP && bit_end && byte_idx != 2'd2)
      frame_sr <= frame_sr << 8;
  end

  // Sticky overflow: a write dropped because the FIFO was full with no pop
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                 overflow <= 1'b0;
    else if (wr_en && fifo_full && !fifo_pop)  overflow <= 1'b1;
  end

  // Line driver decoded from registered state; idle high
  always_comb begin
    uart_tx = 1'b1;
    case (st_q)
      ST_START:  uart_tx = 1'b0;
      ST_DATA:   uart_tx = cur_byte[bit_idx];
`ifdef BRIDGE_PARITY_EN
      ST_PARITY: uart_tx = ^cur_byte;
`endif
      default:   uart_tx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_bus_uart_tx_bridge.sv
// Scoreboard bench for bus_uart_tx_bridge with CLKS_PER_BIT=4.
// Honours BRIDGE_PARITY_EN when the design is built with it.
module tb_bus_uart_tx_bridge;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef BRIDGE_PARITY_EN
  localparam int NBITS      = 11;
  localparam int FRAME_CLKS = 33 * CPB;
`else
  localparam int NBITS      = 10;
  localparam int FRAME_CLKS = 30 * CPB;
`endif

  logic        clk     = 1'b0;
  logic        rstn    = 1'b1;
  logic        wr_en   = 1'b0;
  logic [14:0] wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        busy;
  logic        uart_tx;
  logic        overflow;
  logic [2:0]  fifo_count;
  logic [3:0]  state;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int wr_cyc = 0;
  int exp_cnt [8];
  logic [7:0] exp_q [$];

  bus_uart_tx_bridge #(
    .DATA_WIDTH   (8),
    .ADDRS_WIDTH  (15),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .uart_tx    (uart_tx),
    .overflow   (overflow),
    .fifo_count (fifo_count),
    .state      (state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic [14:0] a, input logic [7:0] d);
    exp_q.push_back({1'b1, a[14:8]});
    exp_q.push_back(a[7:0]);
    exp_q.push_back(d);
  endtask

  // n back-to-back writes; exp_cnt[i] is the occupancy after write i.
  // Write drop_idx is not expected on the line; record=0 expects none.
  task automatic burst(input int n, input logic [14:0] base, input logic [7:0] d0,
                       input int drop_idx, input bit record);
    logic [14:0] a;
    logic [7:0]  d;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check_eq("fifo_count", fifo_count, exp_cnt[i-1]);
        check_eq("busy", busy, (exp_cnt[i-1] == DEPTH));
      end
      if (i == 0) wr_cyc = cyc + 1;
      a = base + 15'(i * 32'h0911);
      d = d0 + 8'(i * 59);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      if (record && i != drop_idx) push_exp(a, d);
    end
    @(negedge clk);
    check_eq("fifo_count", fifo_count, exp_cnt[n-1]);
    check_eq("busy", busy, (exp_cnt[n-1] == DEPTH));
    wr_en = 1'b0;
  endtask

  // Receive n frames, sampling each bit mid-period, and score each byte
  task automatic recv_frames(input int n, input bit chk_lat, input bit tight);
    int t;
    int fstart;
    logic [NBITS-1:0] bits;
    logic [7:0] got;
    logic [7:0] e;
    fstart = 0;
    @(negedge clk);
    for (int f = 0; f < n; f++) begin
      for (int b = 0; b < 3; b++) begin
        if (b == 0) begin
          t = 0;
          while (uart_tx !== 1'b0 && t < 3000) begin
            @(negedge clk);
            t++;
          end
          if (uart_tx !== 1'b0) begin
            check_eq("frame_timeout", 32'd1, 32'd0);
            return;
          end
          fstart = cyc;
          if (chk_lat && f == 0) check_eq("start_latency", cyc - wr_cyc, 2);
          if (tight && f > 0)    check_eq("interframe_gap", t, 1);
        end else begin
          check_eq("byte_gap", uart_tx, 1'b0);
        end
        for (int k = 0; k < NBITS; k++) begin
          repeat (CPB / 2) @(negedge clk);
          bits[k] = uart_tx;
          repeat (CPB - CPB / 2) @(negedge clk);
        end
        got = bits[8:1];
        check_eq("start_bit", bits[0], 1'b0);
        check_eq("stop_bit", bits[NBITS-1], 1'b1);
`ifdef BRIDGE_PARITY_EN
        check_eq("parity_bit", bits[9], ^got);
`endif
        if (exp_q.size() == 0) begin
          check_eq("unexpected_byte", got, 32'hFFFF);
        end else begin
          e = exp_q.pop_front();
          check_eq("byte", got, e);
        end
        if (b == 2) check_eq("frame_len", cyc - fstart, FRAME_CLKS);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    #1 rstn = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_uart_tx", uart_tx, 1'b1);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_overflow", overflow, 1'b0);
    check_eq("rst_fifo_count", fifo_count, 0);
    check_eq("rst_state", state, 0);
    @(negedge clk);
    rstn = 1'b1;

    // Single write: bytes A0 00 5A, start bit two edges after wr_en
    exp_cnt = '{1, 0, 0, 0, 0, 0, 0, 0};
    fork
      burst(1, 15'h2000, 8'h5A, -1, 1'b1);
      recv_frames(1, 1'b1, 1'b0);
    join
    repeat (3) @(negedge clk);
    check_eq("idle_state", state, 0);
    check_eq("idle_count", fifo_count, 0);
    check_eq("idle_line", uart_tx, 1'b1);

    // Four back-to-back writes, LOAD pops one along the way
    exp_cnt = '{1, 2, 2, 3, 0, 0, 0, 0};
    fork
      burst(4, 15'h1234, 8'h81, -1, 1'b1);
      recv_frames(4, 1'b0, 1'b1);
    join
    check_eq("no_overflow", overflow, 1'b0);

    // Six writes: sixth hits a full FIFO and is dropped
    exp_cnt = '{1, 2, 2, 3, 4, 4, 0, 0};
    fork
      begin
        burst(6, 15'h7F00, 8'hF0, 5, 1'b1);
        check_eq("overflow_set", overflow, 1'b1);
      end
      recv_frames(5, 1'b0, 1'b1);
    join
    repeat (5) @(negedge clk);
    check_eq("overflow_sticky", overflow, 1'b1);
    check_eq("sb_drained", exp_q.size(), 0);

    // Full FIFO plus LOAD pop in the same cycle: write accepted
    do_reset();
    check_eq("overflow_cleared", overflow, 1'b0);
    fork
      begin : full_pop
        int t;
        exp_cnt = '{1, 0, 0, 0, 0, 0, 0, 0};
        burst(1, 15'h0101, 8'h10, -1, 1'b1);
        repeat (6) @(negedge clk);
        exp_cnt = '{1, 2, 3, 4, 0, 0, 0, 0};
        burst(4, 15'h4321, 8'hC3, -1, 1'b1);
        t = 0;
        while (state !== 4'd1 && t < 400) begin
          @(negedge clk);
          t++;
        end
        check_eq("load_reached", state, 4'd1);
        wr_en   = 1'b1;
        wr_addr = 15'h5555;
        wr_data = 8'hAA;
        push_exp(15'h5555, 8'hAA);
        @(negedge clk);
        wr_en = 1'b0;
        check_eq("fullpop_count", fifo_count, 4);
        check_eq("fullpop_overflow", overflow, 1'b0);
        check_eq("fullpop_busy", busy, 1'b1);
      end
      recv_frames(6, 1'b0, 1'b1);
    join

    // Reset asserted during DATA of B1 with one entry still queued
    exp_cnt = '{1, 2, 0, 0, 0, 0, 0, 0};
    burst(2, 15'h3C3C, 8'h99, -1, 1'b0);
    repeat (49) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check_eq("midrst_uart_tx", uart_tx, 1'b1);
    check_eq("midrst_state", state, 0);
    check_eq("midrst_count", fifo_count, 0);
    check_eq("midrst_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    begin : quiet
      logic all_high;
      all_high = 1'b1;
      for (int i = 0; i < 60; i++) begin
        @(negedge clk);
        if (uart_tx !== 1'b1) all_high = 1'b0;
      end
      check_eq("no_resume", all_high, 1'b1);
    end
    check_eq("post_rst_state", state, 0);
    exp_cnt = '{1, 0, 0, 0, 0, 0, 0, 0};
    fork
      burst(1, 15'h0ABC, 8'h3E, -1, 1'b1);
      recv_frames(1, 1'b1, 1'b0);
    join

    // Data 0x07: odd number of ones, parity bit 1 under 8E1
    fork
      burst(1, 15'h6001, 8'h07, -1, 1'b1);
      recv_frames(1, 1'b1, 1'b0);
    join
    repeat (5) @(negedge clk);
    check_eq("sb_final_empty", exp_q.size(), 0);
    check_eq("final_state", state, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
